mem_dma_ctrl: RTL

Block-transfer initiator for the 64×16 data memory. It drives the memory's read and write ports on its own, copying a block from one address to another or filling a block with a constant, at one word per cycle. It sits between the control unit and the data memory, and the core muxes it onto the memory ports while `busy` is high. Memory side: writes commit on the clock edge when write enable is high; reads are combinational when read enable is high.

---
 rtl/mem_dma_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_dma_ctrl.sv
// Block-transfer initiator for the data memory: copy or fill one word per cycle,
// using a single stage register between the read port and the write port.
module mem_dma_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic [DATA_WIDTH-1:0] fill_value,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   xfer_count,
   output logic [ADDR_WIDTH-1:0] mem_read_address,
   output logic                  mem_read_enable,
   output logic [ADDR_WIDTH-1:0] mem_write_address,
   output logic                  mem_write_enable,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_t;

   localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   LEN_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] A_ONE   = 1;

   state_t                r_state;
   logic                  r_mode;
   logic                  r_desc;
   logic [DATA_WIDTH-1:0] r_fill;
   logic [ADDR_WIDTH:0]   r_rd_left;
   logic [ADDR_WIDTH-1:0] r_dst_ptr;
   logic [DATA_WIDTH-1:0] r_stage;
   logic                  r_we;
   logic                  r_rd_en;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic [ADDR_WIDTH:0]   r_xfer_count;

   logic [ADDR_WIDTH:0]   w_src_end;
   logic [ADDR_WIDTH:0]   w_dst_end;
   logic                  w_req_ok;
   logic                  w_desc;
   logic [ADDR_WIDTH-1:0] w_len_m1;
   logic [ADDR_WIDTH-1:0] w_src_first;
   logic [ADDR_WIDTH-1:0] w_dst_first;
   logic [ADDR_WIDTH-1:0] w_rd_next;
   logic [ADDR_WIDTH-1:0] w_dst_next;

   // NOTE: every output of this block is assigned on every path, so no latch can form.
   always_comb begin
      // One extra bit keeps base+length from wrapping before the bound compare.
      w_src_end   = {1'b0, src_addr} + length;
      w_dst_end   = {1'b0, dst_addr} + length;
      w_req_ok    = (w_dst_end <= DEPTH) && (mode || (w_src_end <= DEPTH));
      w_desc      = !mode && (dst_addr > src_addr);
      w_len_m1    = length[ADDR_WIDTH-1:0] - A_ONE;
      w_src_first = w_desc ? src_addr + w_len_m1 : src_addr;
      w_dst_first = w_desc ? dst_addr + w_len_m1 : dst_addr;
      w_rd_next   = r_desc ? r_rd_addr - A_ONE : r_rd_addr + A_ONE;
      w_dst_next  = r_desc ? r_dst_ptr - A_ONE : r_dst_ptr + A_ONE;
   end

   // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_mode       <= 1'b0;
         r_desc       <= 1'b0;
         r_fill       <= '0;
         r_rd_left    <= '0;
         r_dst_ptr    <= '0;
         r_stage      <= '0;
         r_we         <= 1'b0;
         r_rd_en      <= 1'b0;
         r_rd_addr    <= '0;
         r_wr_addr    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_xfer_count <= '0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (r_we) r_xfer_count <= r_xfer_count + LEN_ONE;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (!w_req_ok) begin
                     r_error <= 1'b1;
                  end else begin
                     r_mode       <= mode;
                     r_desc       <= w_desc;
                     r_fill       <= fill_value;
                     r_rd_left    <= length;
                     r_dst_ptr    <= w_dst_first;
                     r_xfer_count <= '0;
                     if (length == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        if (!mode) begin
                           r_rd_en   <= 1'b1;
                           r_rd_addr <= w_src_first;
                        end
                     end
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_rd_en <= 1'b0;
                  r_we    <= 1'b0;
               end else begin
                  // The word read now is written next cycle at the matching destination.
                  r_stage   <= r_mode ? r_fill : mem_data_out;
                  r_we      <= 1'b1;
                  r_wr_addr <= r_dst_ptr;
                  r_dst_ptr <= w_dst_next;
                  r_rd_left <= r_rd_left - LEN_ONE;
                  if (r_rd_left == LEN_ONE) begin
                     r_state <= S_LAST;
                     r_rd_en <= 1'b0;
                  end else if (!r_mode) begin
                     r_rd_addr <= w_rd_next;
                  end
               end
            end
            S_LAST: begin
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= abort ? S_IDLE : S_DONE;
               r_done  <= !abort;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy              = r_busy;
   assign done              = r_done;
   assign error             = r_error;
   assign xfer_count        = r_xfer_count;
   assign mem_read_address  = r_rd_addr;
   assign mem_read_enable   = r_rd_en;
   assign mem_write_address = r_wr_addr;
   assign mem_write_enable  = r_we;
   assign mem_data_in       = r_stage;

endmodule
